// File: rtl/axis_dsnk_ctl.sv
// rtl/axis_dsnk_ctl.sv - AXI-Stream data sink with byte/beat/packet counters, rotating checksum,
// LFSR-driven TREADY throttling and an auto-stop byte limit.
module axis_dsnk_ctl #(
  parameter int          C_S_AXIS_TDATA_NUM_BYTES = 4,
  parameter int          C_CNT_WIDTH              = 32,
  parameter int          C_CKSUM_WIDTH            = 64,
  parameter logic [15:0] C_LFSR_SEED              = 16'hACE1
) (
  input  logic                                    AXIS_ACLK,
  input  logic                                    AXIS_ARESETN,
  output logic                                    S_AXIS_TREADY,
  input  logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_NUM_BYTES-1:0]     S_AXIS_TSTRB,
  input  logic                                    S_AXIS_TLAST,
  input  logic                                    S_AXIS_TVALID,
  input  logic [31:0]                             cmd,
  input  logic                                    new_cmd,
  input  logic [C_CNT_WIDTH-1:0]                  byte_limit,
  output logic [31:0]                             stat,
  output logic [C_CNT_WIDTH-1:0]                  recv_bytes,
  output logic [C_CNT_WIDTH-1:0]                  recv_beats,
  output logic [C_CNT_WIDTH-1:0]                  recv_pkts,
  output logic [C_CKSUM_WIDTH-1:0]                checksum
);

  localparam int NB = C_S_AXIS_TDATA_NUM_BYTES;
  localparam int DW = 8 * NB;
  localparam int SW = C_CNT_WIDTH + 1;

  localparam logic [3:0] OP_START = 4'd1;
  localparam logic [3:0] OP_CLEAR = 4'd2;
  localparam logic [3:0] OP_STOP  = 4'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                   state_q, state_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic                     throttle_q, throttle_d;
  logic [C_CNT_WIDTH-1:0]   limit_q, limit_d;
  logic [C_CNT_WIDTH-1:0]   bytes_q, bytes_d;
  logic [C_CNT_WIDTH-1:0]   beats_q, beats_d;
  logic [C_CNT_WIDTH-1:0]   pkts_q, pkts_d;
  logic [C_CKSUM_WIDTH-1:0] cksum_q, cksum_d;
  logic                     in_pkt_q, in_pkt_d;
  logic                     over_q, over_d;

  logic [C_CNT_WIDTH-1:0]   pcnt;
  logic [DW-1:0]            data_m;
  logic [SW-1:0]            byte_sum;
  logic                     limit_hit;
  logic                     xfer;
  logic [3:0]               op;
  logic                     lfsr_fb;
  logic                     unused_cmd_bits;

  assign unused_cmd_bits = ^cmd[31:5];

  // Ready comes only from registers, so it can never combinationally follow TVALID.
  assign S_AXIS_TREADY = (state_q == ST_RUN) & (~throttle_q | lfsr_q[0]);
  assign xfer          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign op            = new_cmd ? cmd[3:0] : 4'd0;
  assign lfsr_fb       = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    pcnt   = '0;
    data_m = '0;
    for (int i = 0; i < NB; i++) begin
      if (S_AXIS_TSTRB[i]) begin
        pcnt              = pcnt + C_CNT_WIDTH'(1);
        data_m[8*i +: 8]  = S_AXIS_TDATA[8*i +: 8];
      end
    end
  end

  // Compared one bit wider so a limit near the counter maximum is still reached.
  assign byte_sum  = {1'b0, bytes_q} + {1'b0, pcnt};
  assign limit_hit = (limit_q != '0) && (byte_sum >= {1'b0, limit_q});

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    throttle_d = throttle_q;
    limit_d    = limit_q;
    bytes_d    = bytes_q;
    beats_d    = beats_q;
    pkts_d     = pkts_q;
    cksum_d    = cksum_q;
    in_pkt_d   = in_pkt_q;
    over_d     = over_q;

    if (state_q == ST_RUN) begin
      lfsr_d = {lfsr_fb, lfsr_q[15:1]};
    end

    if (xfer) begin
      bytes_d  = byte_sum[C_CNT_WIDTH-1:0];
      beats_d  = beats_q + C_CNT_WIDTH'(1);
      pkts_d   = pkts_q + (S_AXIS_TLAST ? C_CNT_WIDTH'(1) : C_CNT_WIDTH'(0));
      in_pkt_d = ~S_AXIS_TLAST;
      cksum_d  = {cksum_q[0], cksum_q[C_CKSUM_WIDTH-1:1]} + C_CKSUM_WIDTH'(data_m);
      if (limit_hit) begin
        over_d = byte_sum > {1'b0, limit_q};
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (op == OP_START) begin
          state_d    = ST_RUN;
          limit_d    = byte_limit;
          throttle_d = cmd[4];
        end
      end
      ST_RUN: begin
        if (op == OP_STOP) begin
          state_d = ST_IDLE;
        end else if (xfer && limit_hit) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = state_q;
    endcase

    // CLEAR overrides everything, including a beat accepted in the same cycle.
    if (op == OP_CLEAR) begin
      state_d    = ST_IDLE;
      lfsr_d     = C_LFSR_SEED;
      throttle_d = 1'b0;
      bytes_d    = '0;
      beats_d    = '0;
      pkts_d     = '0;
      cksum_d    = '0;
      in_pkt_d   = 1'b0;
      over_d     = 1'b0;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= C_LFSR_SEED;
      throttle_q <= 1'b0;
      limit_q    <= '0;
      bytes_q    <= '0;
      beats_q    <= '0;
      pkts_q     <= '0;
      cksum_q    <= '0;
      in_pkt_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      throttle_q <= throttle_d;
      limit_q    <= limit_d;
      bytes_q    <= bytes_d;
      beats_q    <= beats_d;
      pkts_q     <= pkts_d;
      cksum_q    <= cksum_d;
      in_pkt_q   <= in_pkt_d;
      over_q     <= over_d;
    end
  end

  assign stat       = {27'h0, over_q, in_pkt_q, throttle_q,
                       state_q == ST_DONE, state_q == ST_RUN};
  assign recv_bytes = bytes_q;
  assign recv_beats = beats_q;
  assign recv_pkts  = pkts_q;
  assign checksum   = cksum_q;

endmodule

// File: tb/tb_axis_dsnk_ctl.sv
// tb/tb_axis_dsnk_ctl.sv - randomized self-checking bench for axis_dsnk_ctl against a
// transaction-level model of the sink's counters, checksum, status and throttle.
module tb_axis_dsnk_ctl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tready;
  logic [31:0] tdata = '0;
  logic [3:0]  tstrb = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic [31:0] cmd = '0;
  logic        new_cmd = 1'b0;
  logic [31:0] byte_limit = '0;
  logic [31:0] stat;
  logic [31:0] recv_bytes, recv_beats, recv_pkts;
  logic [63:0] checksum;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state
  logic        m_run, m_done, m_thr, m_inpkt, m_over;
  logic [15:0] m_lfsr;
  logic [31:0] m_lim, m_bytes, m_beats, m_pkts;
  logic [63:0] m_ck;

  always #5 clk = ~clk;

  axis_dsnk_ctl dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TVALID (tvalid),
    .cmd           (cmd),
    .new_cmd       (new_cmd),
    .byte_limit    (byte_limit),
    .stat          (stat),
    .recv_bytes    (recv_bytes),
    .recv_beats    (recv_beats),
    .recv_pkts     (recv_pkts),
    .checksum      (checksum)
  );

  task automatic model_reset();
    m_run = 0; m_done = 0; m_thr = 0; m_inpkt = 0; m_over = 0;
    m_lfsr = SEED; m_lim = 0; m_bytes = 0; m_beats = 0; m_pkts = 0; m_ck = 0;
  endtask

  task automatic model_edge(input logic xfer, input logic [31:0] d, input logic [3:0] s,
                            input logic l, input logic [3:0] op, input logic thr);
    logic [32:0] sum;
    logic [31:0] md;
    logic        hit;
    if (op == 4'd2) begin
      model_reset();
      return;
    end
    if (m_run) m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    hit = 0;
    if (xfer) begin
      md = 0;
      for (int i = 0; i < 4; i++) if (s[i]) md[8*i +: 8] = d[8*i +: 8];
      sum = {1'b0, m_bytes} + 33'($countones(s));
      m_bytes = sum[31:0];
      m_beats = m_beats + 1;
      if (l) m_pkts = m_pkts + 1;
      m_inpkt = !l;
      m_ck = {m_ck[0], m_ck[63:1]} + {32'h0, md};
      if (m_lim != 0 && sum >= {1'b0, m_lim}) begin
        hit = 1;
        m_over = sum > {1'b0, m_lim};
      end
    end
    if (op == 4'd1 && !m_run && !m_done) begin
      m_run = 1; m_lim = byte_limit; m_thr = thr;
    end else if (op == 4'd3 && m_run) begin
      m_run = 0;
    end else if (hit && m_run) begin
      m_run = 0; m_done = 1;
    end
  endtask

  // One clock: drive inputs at the falling edge, check TREADY, update the model on the rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] s, input logic l,
                      input logic nc, input logic [31:0] c, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    tvalid = v; tdata = d; tstrb = s; tlast = l; new_cmd = nc; cmd = c;
    #1;
    exp_rdy = m_run && (!m_thr || m_lfsr[0]);
    n_assert++;
    if (tready !== exp_rdy) begin
      n_fail++;
      $display("FAIL tready @%0t: got %b expected %b", $time, tready, exp_rdy);
    end
    acc = v && exp_rdy;
    @(posedge clk);
    model_edge(acc, d, s, l, nc ? c[3:0] : 4'd0, c[4]);
    #2;
    new_cmd = 0;
  endtask

  task automatic cmd_step(input logic [3:0] op, input logic thr);
    logic acc;
    step(0, 0, 0, 0, 1, {27'h0, thr, op}, acc);
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    logic acc;
    step(1, d, s, l, 0, 0, acc);
  endtask

  task automatic check_all(input string name);
    logic [31:0] es;
    es = {27'h0, m_over, m_inpkt, m_thr, m_done, m_run};
    n_assert += 5;
    if (recv_bytes !== m_bytes) begin n_fail++; $display("FAIL %s bytes: got %0d expected %0d", name, recv_bytes, m_bytes); end
    if (recv_beats !== m_beats) begin n_fail++; $display("FAIL %s beats: got %0d expected %0d", name, recv_beats, m_beats); end
    if (recv_pkts !== m_pkts) begin n_fail++; $display("FAIL %s pkts: got %0d expected %0d", name, recv_pkts, m_pkts); end
    if (checksum !== m_ck) begin n_fail++; $display("FAIL %s checksum: got %h expected %h", name, checksum, m_ck); end
    if (stat !== es) begin n_fail++; $display("FAIL %s stat: got %h expected %h", name, stat, es); end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_all("reset");
    n_assert++;
    if (tready !== 1'b0) begin n_fail++; $display("FAIL reset tready: got %b expected 0", tready); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    byte_limit = 0;
    cmd_step(4'd1, 0);
    for (int i = 1; i <= 8; i++) beat(32'(i), 4'hF, i == 8);
    check_all("basic");
    n_assert += 3;
    if (recv_bytes !== 32) begin n_fail++; $display("FAIL basic bytes32: got %0d expected 32", recv_bytes); end
    if (recv_beats !== 8) begin n_fail++; $display("FAIL basic beats8: got %0d expected 8", recv_beats); end
    if (stat[3] !== 1'b0) begin n_fail++; $display("FAIL basic in_pkt: got %b expected 0", stat[3]); end
  endtask

  task automatic test_strobe();
    cmd_step(4'd2, 0);
    cmd_step(4'd1, 0);
    beat(32'hFFFFFFFF, 4'b0011, 0);
    check_all("strobe");
    n_assert += 2;
    if (recv_bytes !== 2) begin n_fail++; $display("FAIL strobe bytes: got %0d expected 2", recv_bytes); end
    if (checksum !== 64'h0000FFFF) begin n_fail++; $display("FAIL strobe cksum: got %h expected 0000ffff", checksum); end
    beat(32'h12345678, 4'b0000, 1);
    check_all("strobe_zero");
  endtask

  task automatic test_limit();
    logic acc;
    cmd_step(4'd2, 0);
    byte_limit = 10;
    cmd_step(4'd1, 0);
    for (int i = 0; i < 6; i++) step(1, 32'hA0 + 32'(i), 4'hF, 0, 0, 0, acc);
    check_all("limit");
    n_assert += 4;
    if (recv_bytes !== 12) begin n_fail++; $display("FAIL limit bytes: got %0d expected 12", recv_bytes); end
    if (recv_beats !== 3) begin n_fail++; $display("FAIL limit beats: got %0d expected 3", recv_beats); end
    if (stat[1] !== 1'b1) begin n_fail++; $display("FAIL limit done: got %b expected 1", stat[1]); end
    if (stat[4] !== 1'b1) begin n_fail++; $display("FAIL limit overshoot: got %b expected 1", stat[4]); end
    cmd_step(4'd1, 0);
    cmd_step(4'd3, 0);
    check_all("limit_start_ignored");
    cmd_step(4'd2, 0);
    check_all("limit_clear");
    n_assert++;
    if ({stat, recv_bytes, recv_beats} !== 96'h0) begin n_fail++; $display("FAIL limit clear zero: got %h %0d %0d expected 0", stat, recv_bytes, recv_beats); end
    byte_limit = 0;
  endtask

  task automatic test_throttle();
    logic [31:0] q[$];
    logic [31:0] accd[$];
    logic [15:0] l;
    logic [31:0] sv_bytes, sv_beats;
    logic [63:0] sv_ck;
    logic        acc;
    int          ones;
    l = SEED; ones = 0;
    for (int i = 0; i < 64; i++) begin
      ones += int'(l[0]);
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
      q.push_back($urandom);
    end
    cmd_step(4'd1, 1);
    for (int i = 0; i < 64; i++) begin
      step(1, q[0], 4'hF, 0, 0, 0, acc);
      if (acc) accd.push_back(q.pop_front());
    end
    check_all("throttle");
    n_assert++;
    if (recv_beats !== 32'(ones)) begin n_fail++; $display("FAIL throttle ones: got %0d expected %0d", recv_beats, ones); end
    sv_bytes = m_bytes; sv_beats = m_beats; sv_ck = m_ck;
    cmd_step(4'd2, 0);
    cmd_step(4'd1, 0);
    foreach (accd[i]) beat(accd[i], 4'hF, 0);
    n_assert += 3;
    if (recv_bytes !== sv_bytes) begin n_fail++; $display("FAIL unthrottled bytes: got %0d expected %0d", recv_bytes, sv_bytes); end
    if (recv_beats !== sv_beats) begin n_fail++; $display("FAIL unthrottled beats: got %0d expected %0d", recv_beats, sv_beats); end
    if (checksum !== sv_ck) begin n_fail++; $display("FAIL unthrottled cksum: got %h expected %h", checksum, sv_ck); end
  endtask

  task automatic test_collisions();
    logic acc;
    cmd_step(4'd2, 0);
    cmd_step(4'd1, 0);
    beat(32'h11, 4'hF, 0);
    step(1, 32'h22, 4'hF, 0, 1, 32'd2, acc);
    check_all("clear_collide");
    n_assert++;
    if ({recv_bytes, recv_beats, checksum} !== 128'h0) begin n_fail++; $display("FAIL clear_collide zero: got %0d %0d %h expected 0", recv_bytes, recv_beats, checksum); end
    cmd_step(4'd1, 0);
    beat(32'h31, 4'hF, 0);
    beat(32'h32, 4'hF, 0);
    step(1, 32'h33, 4'hF, 0, 1, 32'd3, acc);
    check_all("stop_collide");
    step(1, 32'h34, 4'hF, 1, 0, 0, acc);
    check_all("stopped");
    cmd_step(4'd1, 0);
    beat(32'h34, 4'hF, 0);
    beat(32'h35, 4'hF, 1);
    check_all("restart");
    n_assert += 2;
    if (recv_beats !== 5) begin n_fail++; $display("FAIL restart beats: got %0d expected 5", recv_beats); end
    if (recv_pkts !== 1) begin n_fail++; $display("FAIL restart pkts: got %0d expected 1", recv_pkts); end
  endtask

  task automatic test_random();
    logic acc, nc;
    logic [31:0] c;
    cmd_step(4'd2, 0);
    cmd_step(4'd1, 0);
    for (int i = 0; i < 400; i++) begin
      nc = ($urandom_range(15) == 0);
      c  = {27'h0, 1'($urandom_range(1)), 4'($urandom_range(4))};
      byte_limit = ($urandom_range(1) == 1) ? 32'($urandom_range(60, 1)) : 32'h0;
      step(1'($urandom_range(3) != 0), $urandom, 4'($urandom_range(15)),
           ($urandom_range(3) == 0), nc, c, acc);
      check_all("random");
    end
  endtask

  task automatic test_async_reset();
    cmd_step(4'd2, 0);
    cmd_step(4'd1, 0);
    beat(32'hDEAD, 4'hF, 0);
    beat(32'hBEEF, 4'hF, 0);
    @(negedge clk);
    tvalid = 1; tdata = 32'hCAFE; tstrb = 4'hF; tlast = 0;
    @(posedge clk);
    model_edge(1, 32'hCAFE, 4'hF, 0, 0, 0);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    check_all("async_reset");
    n_assert++;
    if (tready !== 1'b0) begin n_fail++; $display("FAIL async_reset tready: got %b expected 0", tready); end
    tvalid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_limit();
    test_throttle();
    test_collisions();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
